// File: rtl/tmds_pkg.sv
// tmds_pkg: shared types, control tokens and helpers for the TMDS encoder.
//   tmds_word_t  : one 10-bit TMDS symbol, bit 0 transmitted first
//   CTL_00..11   : control-period tokens indexed by {c1,c0}
//   N_CH         : number of colour channels
//   popcount8()  : number of ones in a byte
//   ctl_token()  : maps {c1,c0} onto its control token
package tmds_pkg;

  typedef logic [9:0] tmds_word_t;

  localparam int N_CH = 3;

  localparam tmds_word_t CTL_00 = 10'b1101010100;
  localparam tmds_word_t CTL_01 = 10'b0010101011;
  localparam tmds_word_t CTL_10 = 10'b0101010100;
  localparam tmds_word_t CTL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, d[i]};
    end
    return c;
  endfunction

  function automatic tmds_word_t ctl_token(input logic [1:0] c);
    tmds_word_t t;
    case (c)
      2'b00:   t = CTL_00;
      2'b01:   t = CTL_01;
      2'b10:   t = CTL_10;
      2'b11:   t = CTL_11;
      default: t = CTL_00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// tmds_channel_enc: one TMDS 8b/10b channel encoder with running DC balance.
//   i_clk_pixel : pixel clock
//   i_rst       : synchronous active-high reset
//   i_data      : 8-bit colour component
//   i_blank     : 1 = control period, 0 = active video
//   i_ctl       : {c1,c0} control bits, used while blanked
//   o_tmds      : registered 10-bit symbol, appears two edges after the
//                 edge that captures the inputs
// Pipeline: input capture -> transition-minimised q_m -> DC-balanced symbol.
module tmds_channel_enc
  import tmds_pkg::*;
#(
  parameter int P_CNT_W = 5
) (
  input  logic       i_clk_pixel,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_blank,
  input  logic [1:0] i_ctl,
  output tmds_word_t o_tmds
);

  localparam logic signed [P_CNT_W-1:0] CNT_ZERO = {P_CNT_W{1'b0}};
  localparam logic signed [P_CNT_W-1:0] CNT_TWO  = {{(P_CNT_W-2){1'b0}}, 2'b10};

  // capture rank
  logic [7:0] data_r;
  logic       blank_in_r;
  logic [1:0] ctl_in_r;

  // q_m rank
  logic [3:0] n1d_s;
  logic       use_xnor_s;
  logic [8:0] q_m_s;
  logic [8:0] q_m_r;
  logic       blank_r;
  logic [1:0] ctl_r;

  // output rank
  logic [3:0]                n1_s;
  logic [3:0]                n0_s;
  logic signed [P_CNT_W-1:0] n1_ext_s;
  logic signed [P_CNT_W-1:0] n0_ext_s;
  logic signed [P_CNT_W-1:0] diff_s;
  logic signed [P_CNT_W-1:0] cnt_r;
  logic signed [P_CNT_W-1:0] cnt_nxt_s;
  tmds_word_t                tmds_nxt_s;

  // Input capture; reset parks the pipe in a blanked CTL_00 state so no
  // stale active word can leave after reset is released.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      data_r     <= 8'h00;
      blank_in_r <= 1'b1;
      ctl_in_r   <= 2'b00;
    end else begin
      data_r     <= i_data;
      blank_in_r <= i_blank;
      ctl_in_r   <= i_ctl;
    end
  end

  assign n1d_s      = popcount8(data_r);
  assign use_xnor_s = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (data_r[0] == 1'b0));

  // Transition-minimising chain: XNOR for ones-heavy bytes, XOR otherwise;
  // q_m[8] records which chain was used (1 = XOR).
  always_comb begin
    q_m_s    = 9'd0;
    q_m_s[0] = data_r[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor_s) begin
        q_m_s[i] = q_m_s[i-1] ~^ data_r[i];
      end else begin
        q_m_s[i] = q_m_s[i-1] ^ data_r[i];
      end
    end
    q_m_s[8] = ~use_xnor_s;
  end

  // q_m rank registers, with blank/control delayed alongside.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      q_m_r   <= 9'd0;
      blank_r <= 1'b1;
      ctl_r   <= 2'b00;
    end else begin
      q_m_r   <= q_m_s;
      blank_r <= blank_in_r;
      ctl_r   <= ctl_in_r;
    end
  end

  assign n1_s     = popcount8(q_m_r[7:0]);
  assign n0_s     = 4'd8 - n1_s;
  assign n1_ext_s = {{(P_CNT_W-4){1'b0}}, n1_s};
  assign n0_ext_s = {{(P_CNT_W-4){1'b0}}, n0_s};
  assign diff_s   = n1_ext_s - n0_ext_s;

  // DC balancing: choose inversion of q_m[7:0] so the running disparity
  // moves towards zero. Blanking restarts the disparity from zero.
  always_comb begin
    tmds_nxt_s = CTL_00;
    cnt_nxt_s  = CNT_ZERO;
    if (blank_r) begin
      tmds_nxt_s = ctl_token(ctl_r);
      cnt_nxt_s  = CNT_ZERO;
    end else if ((cnt_r == CNT_ZERO) || (n1_s == n0_s)) begin
      tmds_nxt_s = {~q_m_r[8], q_m_r[8], (q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0])};
      cnt_nxt_s  = q_m_r[8] ? (cnt_r + diff_s) : (cnt_r - diff_s);
    end else if ((!cnt_r[P_CNT_W-1] && (n1_s > n0_s)) ||
                 ( cnt_r[P_CNT_W-1] && (n0_s > n1_s))) begin
      // cnt is known non-zero here, so a clear sign bit means cnt > 0
      tmds_nxt_s = {1'b1, q_m_r[8], ~q_m_r[7:0]};
      cnt_nxt_s  = cnt_r + (q_m_r[8] ? CNT_TWO : CNT_ZERO) - diff_s;
    end else begin
      tmds_nxt_s = {1'b0, q_m_r[8], q_m_r[7:0]};
      cnt_nxt_s  = cnt_r + diff_s - (q_m_r[8] ? CNT_ZERO : CNT_TWO);
    end
  end

  // Output symbol and running disparity registers.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      o_tmds <= CTL_00;
      cnt_r  <= CNT_ZERO;
    end else begin
      o_tmds <= tmds_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: three-channel DVI TMDS encoder fed by vga_gen.
//   i_clk_pixel : pixel clock, the only clock
//   i_rst       : synchronous active-high reset
//   i_hsync     : horizontal sync
//   i_vsync     : vertical sync
//   i_blank     : 1 = control period, 0 = active video
//   i_data      : [0]=red, [1]=green, [2]=blue
//   o_tmds      : [0]=ch0/blue, [1]=ch1/green, [2]=ch2/red, registered
// Only sync polarity, channel/control mapping and port arrays live here;
// each lane is a tmds_channel_enc. P_CNT_W must be at least 5.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter bit P_SYNC_INVERT = 1'b0,
  parameter int P_CNT_W       = 5
) (
  input  logic            i_clk_pixel,
  input  logic            i_rst,
  input  logic            i_hsync,
  input  logic            i_vsync,
  input  logic            i_blank,
  input  logic [2:0][7:0] i_data,
  output logic [2:0][9:0] o_tmds
);

  logic                  hsync_s;
  logic                  vsync_s;
  logic [N_CH-1:0][7:0]  chan_data_s;
  logic [N_CH-1:0][1:0]  chan_ctl_s;

  assign hsync_s = i_hsync ^ P_SYNC_INVERT;
  assign vsync_s = i_vsync ^ P_SYNC_INVERT;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    // channel order is reversed relative to the colour inputs (ch0 = blue)
    assign chan_data_s[ch] = i_data[N_CH-1-ch];
    // only ch0 carries sync during blanking
    assign chan_ctl_s[ch]  = (ch == 0) ? {vsync_s, hsync_s} : 2'b00;

    tmds_channel_enc #(
      .P_CNT_W (P_CNT_W)
    ) u_enc (
      .i_clk_pixel (i_clk_pixel),
      .i_rst       (i_rst),
      .i_data      (chan_data_s[ch]),
      .i_blank     (i_blank),
      .i_ctl       (chan_ctl_s[ch]),
      .o_tmds      (o_tmds[ch])
    );
  end

endmodule
